// File: rtl/logicnet_input_packer_if.sv
// Stream bundle for the layer-0 input packer: feature stream in, packed vector out.
interface logicnet_input_packer_if #(
    parameter int FEAT_BITS = 2,
    parameter int NUM_FEAT  = 32
);
    localparam int OUT_W = FEAT_BITS * NUM_FEAT;

    logic                 s_valid;
    logic                 s_ready;
    logic [FEAT_BITS-1:0] s_data;
    logic                 s_last;
    logic                 m_valid;
    logic                 m_ready;
    logic [OUT_W-1:0]     m_data;

    // Packer side.
    modport slave (
        input  s_valid, s_data, s_last, m_ready,
        output s_ready, m_valid, m_data
    );

    // Feature source / vector sink side.
    modport master (
        output s_valid, s_data, s_last, m_ready,
        input  s_ready, m_valid, m_data
    );
endinterface

// File: rtl/logicnet_input_packer.sv
// Assembles NUM_FEAT quantized features into one flat vector for layer 0,
// double-buffered (assembly + output register), with short/long frame recovery.
module logicnet_input_packer #(
    parameter int FEAT_BITS = 2,
    parameter int NUM_FEAT  = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    logicnet_input_packer_if.slave   bus,
    output logic                     err_len
);
    localparam int OUT_W = FEAT_BITS * NUM_FEAT;
    localparam int IDX_W = (NUM_FEAT > 1) ? $clog2(NUM_FEAT) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_FEAT - 1);

    typedef enum logic [1:0] {FILL, WAIT, DISCARD} state_t;

    state_t           state, state_n;
    logic [IDX_W-1:0] idx, idx_n;
    logic             long_q, long_n;
    logic             err_n;
    logic             rdy_q;
    logic             load, load_asm;
    logic [OUT_W-1:0] asm_q, asm_full;
    logic             mv_q;
    logic [OUT_W-1:0] md_q;
    logic             accept, slot_free;

    assign accept    = bus.s_valid && rdy_q;
    assign slot_free = !mv_q || bus.m_ready;

    assign bus.s_ready = rdy_q;
    assign bus.m_valid = mv_q;
    assign bus.m_data  = md_q;

    // Assembly contents with the current beat merged in, so a completing beat
    // can go straight to the output register on the same edge.
    always_comb begin
        asm_full = asm_q;
        asm_full[int'(idx) * FEAT_BITS +: FEAT_BITS] = bus.s_data;
    end

    // Next-state, index and transfer decisions.
    always_comb begin
        state_n  = state;
        idx_n    = idx;
        long_n   = long_q;
        err_n    = 1'b0;
        load     = 1'b0;
        load_asm = 1'b0;
        case (state)
            FILL: begin
                if (accept) begin
                    idx_n = '0;
                    if (idx == LAST_IDX) begin
                        // Vector complete; a missing s_last means extra beats follow.
                        err_n = !bus.s_last;
                        if (slot_free) begin
                            load    = 1'b1;
                            state_n = bus.s_last ? FILL : DISCARD;
                        end else begin
                            state_n = WAIT;
                            long_n  = !bus.s_last;
                        end
                    end else if (bus.s_last) begin
                        // Short frame: drop the partial vector.
                        err_n = 1'b1;
                    end else begin
                        idx_n = idx + 1'b1;
                    end
                end
            end
            WAIT: begin
                if (slot_free) begin
                    load     = 1'b1;
                    load_asm = 1'b1;
                    state_n  = long_q ? DISCARD : FILL;
                    long_n   = 1'b0;
                end
            end
            DISCARD: begin
                if (accept && bus.s_last)
                    state_n = FILL;
            end
            default: state_n = FILL;
        endcase
    end

    // Control state; s_ready is registered from the next state so it never
    // depends combinationally on m_ready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= FILL;
            idx     <= '0;
            long_q  <= 1'b0;
            rdy_q   <= 1'b0;
            err_len <= 1'b0;
        end else begin
            state   <= state_n;
            idx     <= idx_n;
            long_q  <= long_n;
            rdy_q   <= (state_n != WAIT);
            err_len <= err_n;
        end
    end

    // Assembly register: written by every accepted FILL beat, never cleared.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            asm_q <= '0;
        else if (state == FILL && accept)
            asm_q <= asm_full;
    end

    // Output register: loads only on transfer, otherwise holds until consumed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mv_q <= 1'b0;
            md_q <= '0;
        end else if (load) begin
            mv_q <= 1'b1;
            md_q <= load_asm ? asm_q : asm_full;
        end else if (bus.m_ready) begin
            mv_q <= 1'b0;
        end
    end
endmodule

// File: tb/tb_logicnet_input_packer.sv
// Directed + throttled-random bench for logicnet_input_packer with a
// frame-level reference model and a per-cycle output checker.
module tb_logicnet_input_packer;
    localparam int FB = 2;
    localparam int NF = 32;
    localparam int OW = FB * NF;

    typedef logic [FB-1:0] feat_q_t[$];

    logic clk;
    logic rst_n;
    logic err_len;

    logicnet_input_packer_if #(.FEAT_BITS(FB), .NUM_FEAT(NF)) bus();

    logicnet_input_packer #(.FEAT_BITS(FB), .NUM_FEAT(NF)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus),
        .err_len (err_len)
    );

    int checks = 0;
    int errors = 0;
    int exp_err = 0;
    int err_seen = 0;
    logic [OW-1:0] exp_q[$];

    logic mr_rand  = 1'b0;
    logic mr_bit   = 1'b0;
    logic mr_const = 1'b0;
    assign bus.m_ready = mr_rand ? mr_bit : mr_const;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Random sink throttle, changed just after each rising edge.
    always @(posedge clk) begin
        #1;
        mr_bit = ($urandom_range(99) < 70);
    end

    task automatic chk(input string name, input logic [OW-1:0] act, input logic [OW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic give_up(input string why);
        errors++;
        $display("FAIL %s", why);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    endtask

    // Per-cycle output checker: transfers against the model queue, stall stability,
    // and err_len pulse counting.
    logic          prev_stall = 1'b0;
    logic [OW-1:0] prev_data  = '0;
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                checks++;
                if (!(bus.m_valid && bus.m_data == prev_data)) begin
                    errors++;
                    $display("FAIL stall_hold actual=%b/%h required=1/%h",
                             bus.m_valid, bus.m_data, prev_data);
                end
            end
            if (err_len) err_seen++;
            if (bus.m_valid && bus.m_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL xfer_extra actual=%h required=none", bus.m_data);
                end else begin
                    logic [OW-1:0] e;
                    e = exp_q.pop_front();
                    if (bus.m_data !== e) begin
                        errors++;
                        $display("FAIL xfer_data actual=%h required=%h", bus.m_data, e);
                    end
                end
            end
            prev_stall = bus.m_valid && !bus.m_ready;
            prev_data  = bus.m_data;
        end
    end

    // Drive one beat; returns just after the edge that accepted it.
    task automatic send_beat(input logic [FB-1:0] d, input logic last, input int vpct);
        int   g;
        logic ok;
        while (vpct < 100 && $urandom_range(99) >= vpct) begin
            @(posedge clk); #1;
        end
        bus.s_valid = 1'b1;
        bus.s_data  = d;
        bus.s_last  = last;
        g = 0;
        forever begin
            @(negedge clk);
            ok = bus.s_ready;
            @(posedge clk); #1;
            if (ok) break;
            g++;
            if (g > 5000) give_up("s_ready_timeout");
        end
        bus.s_valid = 1'b0;
        bus.s_last  = 1'b0;
    endtask

    // Frame-level model: a frame of at least NF beats yields its first NF
    // features as one vector; any length other than NF is one length error.
    function automatic logic [OW-1:0] pack(input feat_q_t f);
        logic [OW-1:0] v;
        v = '0;
        for (int k = 0; k < NF; k++) v[k*FB +: FB] = f[k];
        return v;
    endfunction

    task automatic send_frame(input feat_q_t f, input int vpct);
        if (f.size() >= NF) exp_q.push_back(pack(f));
        if (f.size() != NF) exp_err++;
        for (int k = 0; k < f.size(); k++)
            send_beat(f[k], (k == f.size() - 1), vpct);
    endtask

    function automatic feat_q_t mk_frame(input int len, input int kind);
        feat_q_t f;
        for (int k = 0; k < len; k++) begin
            case (kind)
                0:       f.push_back(FB'(k % 4));
                1:       f.push_back(FB'(3 - (k % 4)));
                default: f.push_back(FB'($urandom_range(3)));
            endcase
        end
        return f;
    endfunction

    initial begin
        int e0;
        feat_q_t f;
        rst_n = 1'b0;
        bus.s_valid = 1'b0;
        bus.s_data  = '0;
        bus.s_last  = 1'b0;
        #12;
        chk("rst_s_ready", OW'(bus.s_ready), '0);
        chk("rst_m_valid", OW'(bus.m_valid), '0);
        chk("rst_m_data",  bus.m_data, '0);
        chk("rst_err_len", OW'(err_len), '0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        chk("s_ready_after_rst", OW'(bus.s_ready), 64'd1);

        // Exact frame, k%4 pattern, free sink.
        mr_const = 1'b1;
        send_frame(mk_frame(NF, 0), 100);
        chk("exact_m_valid", OW'(bus.m_valid), 64'd1);
        chk("exact_m_data",  bus.m_data, 64'hE4E4E4E4E4E4E4E4);
        chk("exact_err_len", OW'(err_len), '0);
        @(posedge clk); #1;

        // Back-to-back A, B with the sink blocked.
        mr_const = 1'b0;
        send_frame(mk_frame(NF, 0), 100);
        send_frame(mk_frame(NF, 1), 100);
        chk("b2b_s_ready_low", OW'(bus.s_ready), '0);
        chk("b2b_hold_a",      bus.m_data, 64'hE4E4E4E4E4E4E4E4);
        @(posedge clk); #1;
        chk("b2b_still_low",   OW'(bus.s_ready), '0);
        mr_const = 1'b1;
        @(posedge clk); #1;
        mr_const = 1'b0;
        chk("b2b_m_valid_b", OW'(bus.m_valid), 64'd1);
        chk("b2b_m_data_b",  bus.m_data, 64'h1B1B1B1B1B1B1B1B);
        @(posedge clk); #1;
        mr_const = 1'b1;
        @(posedge clk); #1;
        chk("b2b_drained_valid", OW'(bus.m_valid), '0);
        chk("b2b_drained_ready", OW'(bus.s_ready), 64'd1);

        // Short frame: 11 beats.
        send_frame(mk_frame(11, 2), 100);
        chk("short_err_pulse", OW'(err_len), 64'd1);
        chk("short_no_vector", OW'(bus.m_valid), '0);
        @(posedge clk); #1;
        chk("short_err_one_cycle", OW'(err_len), '0);
        f = mk_frame(NF, 2);
        send_frame(f, 100);
        chk("post_short_vector", bus.m_data, pack(f));

        // Long frame: 35 beats, then a normal frame.
        @(posedge clk); #1;
        e0 = err_seen;
        send_frame(mk_frame(35, 2), 100);
        @(posedge clk); #1;
        chk("long_err_count", OW'(err_seen - e0), 64'd1);
        f = mk_frame(NF, 2);
        send_frame(f, 100);
        chk("post_long_vector", bus.m_data, pack(f));
        @(posedge clk); #1;

        // Reset at beat 15 with a vector pending in the output.
        mr_const = 1'b0;
        send_frame(mk_frame(NF, 1), 100);
        for (int k = 0; k < 15; k++) send_beat(FB'($urandom_range(3)), 1'b0, 100);
        #2;
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        chk("midrst_m_valid", OW'(bus.m_valid), '0);
        chk("midrst_m_data",  bus.m_data, '0);
        chk("midrst_s_ready", OW'(bus.s_ready), '0);
        chk("midrst_err_len", OW'(err_len), '0);
        @(posedge clk); @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        mr_const = 1'b1;
        send_frame(mk_frame(NF, 0), 100);
        chk("post_rst_vector", bus.m_data, 64'hE4E4E4E4E4E4E4E4);

        // Throttled random frames, occasionally short or long.
        mr_rand = 1'b1;
        for (int n = 0; n < 1000; n++) begin
            int r, len;
            r = $urandom_range(99);
            if (r < 5)       len = $urandom_range(1, NF - 1);
            else if (r < 10) len = $urandom_range(NF + 1, NF + 8);
            else             len = NF;
            send_frame(mk_frame(len, 2), 75);
        end
        mr_rand  = 1'b0;
        mr_const = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        chk("all_vectors_out", OW'(exp_q.size()), '0);
        chk("err_len_total",   OW'(err_seen), OW'(exp_err));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
